// File: rtl/reg_file_mp.sv
// Multi-port register file with a per-register pending-write scoreboard; x0 reads as zero.
// Reads are combinational (0 cycles), writes are visible the cycle after the edge; no backpressure.
module reg_file_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rs_addr,
   output logic [NRD*XLEN-1:0] rs_data,
   output logic [NRD-1:0]      rs_busy,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   wa,
   input  logic [NWR*XLEN-1:0] wd,
   input  logic                iss_valid,
   input  logic [AW-1:0]       iss_rd
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Ascending port order makes the highest-numbered port win on an address clash;
   // the issue mark is applied last so a new producer overrides a retiring one.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int w = 0; w < NWR; w++) begin
         if (we[w] && (wa[w*AW +: AW] != '0)) begin
            regs_d[wa[w*AW +: AW]] = wd[w*XLEN +: XLEN];
            busy_d[wa[w*AW +: AW]] = 1'b0;
         end
      end
      if (iss_valid && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs_q[r] <= '0;
         end
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            busy;

      assign addr = rs_addr[p*AW +: AW];

      // A value being written this cycle is already produced, so it is never reported busy.
      always_comb begin
         data = regs_q[addr];
         busy = busy_q[addr];
         if (BYPASS != 0) begin
            for (int w = 0; w < NWR; w++) begin
               if (we[w] && (wa[w*AW +: AW] == addr)) begin
                  data = wd[w*XLEN +: XLEN];
                  busy = 1'b0;
               end
            end
         end
         if (addr == '0) begin
            data = '0;
            busy = 1'b0;
         end
      end

      assign rs_data[p*XLEN +: XLEN] = data;
      assign rs_busy[p]              = busy;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed vectors on bypass / non-bypass builds, random run on a 64-bit 3R2W build.
module tb_reg_file_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // shared stimulus for the 32x32, 2R/2W builds (A: bypass, B: no bypass)
   logic        rst;
   logic [1:0]  we;
   logic [4:0]  wa0, wa1, r0, r1, ir;
   logic [31:0] wd0, wd1;
   logic        iv;
   logic [63:0] rd_a, rd_b;
   logic [1:0]  bs_a, bs_b;

   reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .rs_addr({r1, r0}), .rs_data(rd_a), .rs_busy(bs_a),
      .we(we), .wa({wa1, wa0}), .wd({wd1, wd0}), .iss_valid(iv), .iss_rd(ir)
   );

   reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .rs_addr({r1, r0}), .rs_data(rd_b), .rs_busy(bs_b),
      .we(we), .wa({wa1, wa0}), .wd({wd1, wd0}), .iss_valid(iv), .iss_rd(ir)
   );

   // 64-bit, 16 registers, 3 read / 2 write ports
   logic         rst_c;
   logic [11:0]  ra_c;
   logic [191:0] rd_c;
   logic [2:0]   bs_c;
   logic [1:0]   we_c;
   logic [7:0]   wa_c;
   logic [127:0] wd_c;
   logic         iv_c;
   logic [3:0]   ir_c;

   reg_file_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(2), .BYPASS(1)) dut_c (
      .clk(clk), .rst(rst_c), .rs_addr(ra_c), .rs_data(rd_c), .rs_busy(bs_c),
      .we(we_c), .wa(wa_c), .wd(wd_c), .iss_valid(iv_c), .iss_rd(ir_c)
   );

   typedef struct {
      logic        rst;
      logic [1:0]  we;
      logic [4:0]  wa0, wa1;
      logic [31:0] wd0, wd1;
      logic        iv;
      logic [4:0]  ir, r0, r1;
      logic [31:0] ea0, ea1, eb0, eb1;
      logic [1:0]  ba, bb;
   } vec_t;

   localparam int NV = 22;
   vec_t vt [NV];

   logic [63:0] mreg  [16];
   logic        mbusy [16];
   logic [3:0]  a;
   logic [63:0] ed;
   logic        eb;
   int          k;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      //         rst we    wa0 wa1 wd0           wd1        iv ir r0 r1 ea0           ea1           eb0           eb1           ba     bb
      vt[0]  = '{0, 2'b01, 5,  0,  32'hDEADBEEF, 0,         0, 0, 5, 0, 32'hDEADBEEF, 0,            0,            0,            2'b00, 2'b00};
      vt[1]  = '{1, 2'b01, 6,  0,  32'h66,       0,         1, 5, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 2'b00};
      vt[2]  = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 5, 6, 0,            0,            0,            0,            2'b00, 2'b00};
      vt[3]  = '{0, 2'b11, 0,  0,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0,         0,            0,            0,            2'b00, 2'b00};
      vt[4]  = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 0, 0, 0,            0,            0,            0,            2'b00, 2'b00};
      vt[5]  = '{0, 2'b01, 7,  0,  32'h11111111, 0,         0, 0, 7, 7, 32'h11111111, 32'h11111111, 0,            0,            2'b00, 2'b00};
      vt[6]  = '{0, 2'b01, 7,  0,  32'h12345678, 0,         0, 0, 7, 7, 32'h12345678, 32'h12345678, 32'h11111111, 32'h11111111, 2'b00, 2'b00};
      vt[7]  = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 7, 7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 2'b00, 2'b00};
      vt[8]  = '{0, 2'b11, 9,  9,  32'hAAAA,     32'h5555,  0, 0, 9, 7, 32'h5555,     32'h12345678, 0,            32'h12345678, 2'b00, 2'b00};
      vt[9]  = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 9, 9, 32'h5555,     32'h5555,     32'h5555,     32'h5555,     2'b00, 2'b00};
      vt[10] = '{0, 2'b00, 0,  0,  0,            0,         1, 3, 3, 3, 0,            0,            0,            0,            2'b00, 2'b00};
      vt[11] = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 3, 3, 0,            0,            0,            0,            2'b11, 2'b11};
      vt[12] = '{0, 2'b10, 0,  3,  0,            32'h33,    0, 0, 3, 9, 32'h33,       32'h5555,     0,            32'h5555,     2'b00, 2'b01};
      vt[13] = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 3, 3, 32'h33,       32'h33,       32'h33,       32'h33,       2'b00, 2'b00};
      vt[14] = '{0, 2'b01, 3,  0,  32'h44,       0,         1, 3, 3, 3, 32'h44,       32'h44,       32'h33,       32'h33,       2'b00, 2'b00};
      vt[15] = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 3, 3, 32'h44,       32'h44,       32'h44,       32'h44,       2'b11, 2'b11};
      vt[16] = '{0, 2'b01, 3,  0,  32'h55,       0,         1, 3, 3, 3, 32'h55,       32'h55,       32'h44,       32'h44,       2'b00, 2'b11};
      vt[17] = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 3, 3, 32'h55,       32'h55,       32'h55,       32'h55,       2'b11, 2'b11};
      vt[18] = '{0, 2'b00, 0,  0,  0,            0,         1, 0, 0, 3, 0,            32'h55,       0,            32'h55,       2'b10, 2'b10};
      vt[19] = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 0, 3, 0,            32'h55,       0,            32'h55,       2'b10, 2'b10};
      vt[20] = '{1, 2'b00, 0,  0,  0,            0,         0, 0, 3, 3, 32'h55,       32'h55,       32'h55,       32'h55,       2'b11, 2'b11};
      vt[21] = '{0, 2'b00, 0,  0,  0,            0,         0, 0, 3, 3, 0,            0,            0,            0,            2'b00, 2'b00};

      rst = 1'b1; we = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iv = 1'b0; ir = '0; r0 = '0; r1 = '0;
      rst_c = 1'b1; ra_c = '0; we_c = '0; wa_c = '0; wd_c = '0; iv_c = 1'b0; ir_c = '0;
      for (int i = 0; i < 16; i++) begin
         mreg[i]  = '0;
         mbusy[i] = 1'b0;
      end
      @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst = vt[i].rst; we = vt[i].we; wa0 = vt[i].wa0; wa1 = vt[i].wa1;
         wd0 = vt[i].wd0; wd1 = vt[i].wd1; iv = vt[i].iv; ir = vt[i].ir;
         r0 = vt[i].r0; r1 = vt[i].r1;
         #1;
         chk($sformatf("vec%0d bypass data", i), rd_a, {vt[i].ea1, vt[i].ea0});
         chk($sformatf("vec%0d stored data", i), rd_b, {vt[i].eb1, vt[i].eb0});
         chk($sformatf("vec%0d bypass busy", i), bs_a, vt[i].ba);
         chk($sformatf("vec%0d stored busy", i), bs_b, vt[i].bb);
      end

      // every register cleared after the mid-stream reset
      @(negedge clk);
      rst = 1'b0; we = '0; iv = 1'b0;
      for (int i = 0; i < 32; i++) begin
         r0 = 5'(i);
         r1 = 5'(31 - i);
         #1;
         chk($sformatf("cleared x%0d", i), {rd_a, rd_b, bs_a, bs_b}, '0);
      end

      // random run against the model
      for (int n = 0; n < 10000; n++) begin
         @(negedge clk);
         rst_c = ($urandom_range(0, 199) == 0);
         we_c  = 2'($urandom);
         wa_c  = 8'($urandom);
         wd_c  = {$urandom, $urandom, $urandom, $urandom};
         iv_c  = ($urandom_range(0, 2) == 0);
         ir_c  = 4'($urandom);
         for (int p = 0; p < 3; p++) begin
            if ($urandom_range(0, 2) == 0) begin
               k = int'($urandom_range(0, 1));
               ra_c[p*4 +: 4] = wa_c[k*4 +: 4];
            end else begin
               ra_c[p*4 +: 4] = 4'($urandom);
            end
         end
         #1;
         for (int p = 0; p < 3; p++) begin
            a  = ra_c[p*4 +: 4];
            ed = mreg[a];
            eb = mbusy[a];
            for (int w = 0; w < 2; w++) begin
               if (we_c[w] && wa_c[w*4 +: 4] == a) begin
                  ed = wd_c[w*64 +: 64];
                  eb = 1'b0;
               end
            end
            if (a == 4'd0) begin
               ed = '0;
               eb = 1'b0;
            end
            chk($sformatf("rand%0d port%0d x%0d data", n, p, a), rd_c[p*64 +: 64], ed);
            chk($sformatf("rand%0d port%0d x%0d busy", n, p, a), bs_c[p], eb);
         end
         @(posedge clk);
         if (rst_c) begin
            for (int i = 0; i < 16; i++) begin
               mreg[i]  = '0;
               mbusy[i] = 1'b0;
            end
         end else begin
            for (int w = 0; w < 2; w++) begin
               if (we_c[w] && wa_c[w*4 +: 4] != 4'd0) begin
                  mreg[wa_c[w*4 +: 4]]  = wd_c[w*64 +: 64];
                  mbusy[wa_c[w*4 +: 4]] = 1'b0;
               end
            end
            if (iv_c && ir_c != 4'd0) mbusy[ir_c] = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
